// File: rtl/axistream_snooper_wide.sv
// AXI-Stream snooper: copies each accepted packet into a word-addressed
// packet memory, reports byte length / truncation, and counts packets
// that arrive while the memory is busy. Never backpressures the stream.
module axistream_snooper_wide #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   TDATA,
    input  logic [DATA_WIDTH/8-1:0] TKEEP,
    input  logic                    TVALID,
    input  logic                    TREADY,
    input  logic                    TLAST,
    input  logic                    mem_ready,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_en,
    output logic                    done,
    output logic [31:0]             byte_len,
    output logic                    trunc,
    output logic [CNT_WIDTH-1:0]    drop_cnt
);
    localparam int KW = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;
    localparam logic [1:0] SKIP    = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;       // next word address inside a capture
    logic [31:0]           r_cnt;        // running byte count of current packet
    logic                  r_fin;        // finished packet waiting one cycle for done
    logic [31:0]           r_pend_len;
    logic                  r_pend_trunc;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_en;
    logic                  r_done;
    logic [31:0]           r_byte_len;
    logic                  r_trunc;
    logic [CNT_WIDTH-1:0]  r_drop;

    logic                  w_beat;
    logic                  w_last_addr;
    logic [31:0]           w_pop;

    assign w_beat      = TVALID & TREADY;
    assign w_last_addr = (r_addr == {ADDR_WIDTH{1'b1}});

    // Number of valid bytes in the current beat
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < KW; i++)
            w_pop = w_pop + 32'(TKEEP[i]);
    end

    // Capture FSM, write port, and the done/length pipeline. done trails the
    // last write by one cycle, so a finished packet's length is parked in
    // r_pend_* while a back-to-back packet may already be restarting r_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_fin        <= 1'b0;
            r_pend_len   <= '0;
            r_pend_trunc <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_done       <= 1'b0;
            r_byte_len   <= '0;
            r_trunc      <= 1'b0;
            r_drop       <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= r_fin;
            r_fin   <= 1'b0;
            if (r_fin) begin
                r_byte_len <= r_pend_len;
                r_trunc    <= r_pend_trunc;
            end
            if (w_beat) begin
                case (r_state)
                    IDLE: begin
                        if (mem_ready) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= '0;
                            r_wr_data <= TDATA;
                            r_addr    <= ADDR_WIDTH'(1);
                            r_cnt     <= w_pop;
                            if (TLAST) begin
                                r_fin        <= 1'b1;
                                r_pend_len   <= w_pop;
                                r_pend_trunc <= 1'b0;
                            end else begin
                                r_state <= CAPTURE;
                            end
                        end else begin
                            if (r_drop != {CNT_WIDTH{1'b1}})
                                r_drop <= r_drop + CNT_WIDTH'(1);
                            if (!TLAST)
                                r_state <= SKIP;
                        end
                    end
                    CAPTURE: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= TDATA;
                        r_addr    <= r_addr + ADDR_WIDTH'(1);
                        r_cnt     <= r_cnt + w_pop;
                        if (TLAST) begin
                            r_fin        <= 1'b1;
                            r_pend_len   <= r_cnt + w_pop;
                            r_pend_trunc <= 1'b0;
                            r_state      <= IDLE;
                        end else if (w_last_addr) begin
                            r_state <= FULL;
                        end
                    end
                    FULL: begin
                        // Memory exhausted: swallow beats, length frozen
                        if (TLAST) begin
                            r_fin        <= 1'b1;
                            r_pend_len   <= r_cnt;
                            r_pend_trunc <= 1'b1;
                            r_state      <= IDLE;
                        end
                    end
                    default: begin
                        if (TLAST)
                            r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign wr_en    = r_wr_en;
    assign done     = r_done;
    assign byte_len = r_byte_len;
    assign trunc    = r_trunc;
    assign drop_cnt = r_drop;
endmodule

// File: tb/tb_axistream_snooper_wide.sv
// Bench for axistream_snooper_wide: packet-level reference model checked
// every cycle, plus directed packets with hand-computed expectations.
module tb_axistream_snooper_wide;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam int CW = 4;
    localparam int KW = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] TDATA = '0;
    logic [KW-1:0] TKEEP = '0;
    logic          TVALID = 1'b0;
    logic          TREADY = 1'b0;
    logic          TLAST = 1'b0;
    logic          mem_ready = 1'b1;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          done;
    logic [31:0]   byte_len;
    logic          trunc;
    logic [CW-1:0] drop_cnt;

    axistream_snooper_wide #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(TVALID),
        .TREADY(TREADY), .TLAST(TLAST), .mem_ready(mem_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .done(done),
        .byte_len(byte_len), .trunc(trunc), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level reference: beat index within packet, accept decision made
    // at the first beat, writes only for indices that fit the memory.
    logic          started = 1'b0;
    logic          e_wr_en = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic          e_done = 1'b0;
    logic [31:0]   e_len = '0;
    logic          e_trunc = 1'b0;
    logic [CW-1:0] e_drop = '0;
    logic          pend_done = 1'b0;
    logic [31:0]   pend_len = '0;
    logic          pend_trunc = 1'b0;
    logic          in_pkt = 1'b0;
    logic          acc = 1'b0;
    int            idx = 0;
    int            bytes = 0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            e_wr_en = 0; e_addr = '0; e_data = '0; e_done = 0;
            e_len = '0; e_trunc = 0; e_drop = '0;
            pend_done = 0; in_pkt = 0;
        end else begin
            e_done = pend_done;
            if (pend_done) begin
                e_len = pend_len;
                e_trunc = pend_trunc;
            end
            pend_done = 0;
            e_wr_en = 0;
            if (TVALID && TREADY) begin
                if (!in_pkt) begin
                    in_pkt = 1; idx = 0; bytes = 0; acc = mem_ready;
                    if (!acc && e_drop != 4'd15) e_drop = e_drop + 4'd1;
                end
                if (acc && idx < DEPTH) begin
                    e_wr_en = 1;
                    e_addr = AW'(idx);
                    e_data = TDATA;
                    bytes = bytes + $countones(TKEEP);
                end
                if (TLAST) begin
                    in_pkt = 0;
                    if (acc) begin
                        pend_done = 1;
                        pend_len = bytes;
                        pend_trunc = (idx >= DEPTH);
                    end
                end
                idx++;
            end
        end
    end

    // Per-cycle comparison against the model, plus event bookkeeping
    int            ndone = 0;
    int            nwr = 0;
    logic [31:0]   last_len = '0;
    logic          last_trunc = 1'b0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        if (started) begin
            chk("m_wr_en", wr_en, e_wr_en);
            chk("m_wr_addr", wr_addr, e_addr);
            chk("m_wr_data", wr_data, e_data);
            chk("m_done", done, e_done);
            chk("m_byte_len", byte_len, e_len);
            chk("m_trunc", trunc, e_trunc);
            chk("m_drop_cnt", drop_cnt, e_drop);
            if (done === 1'b1) begin
                ndone++; last_len = byte_len; last_trunc = trunc;
            end
            if (wr_en === 1'b1) begin
                nwr++; last_addr = wr_addr;
            end
        end
    end

    task automatic send(input logic [KW-1:0] k, input logic l);
        TDATA = {$urandom, $urandom};
        TKEEP = k; TLAST = l; TVALID = 1; TREADY = 1;
        @(posedge clk); #1;
        TVALID = 0; TLAST = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, w0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_byte_len", byte_len, 0);
        chk("rst_drop", drop_cnt, 0);

        // 3-beat packet FF,FF,0F
        n0 = ndone; w0 = nwr;
        send(8'hFF, 0);
        chk("p1_wr0", {wr_en, wr_addr}, {1'b1, 4'd0});
        send(8'hFF, 0);
        send(8'h0F, 1);
        chk("p1_wr2", {wr_en, wr_addr}, {1'b1, 4'd2});
        chk("p1_no_done_yet", done, 0);
        idle(1);
        chk("p1_done", done, 1);
        chk("p1_len", byte_len, 20);
        chk("p1_trunc", trunc, 0);
        idle(1);
        chk("p1_done_pulse", done, 0);
        chk("p1_len_hold", byte_len, 20);
        chk("p1_nwr", nwr - w0, 3);
        chk("p1_ndone", ndone - n0, 1);

        // dropped 2-beat packet, then a captured one
        n0 = ndone; w0 = nwr;
        mem_ready = 0;
        send(8'hFF, 0);
        mem_ready = 1;
        send(8'hFF, 1);
        idle(3);
        chk("drop_cnt1", drop_cnt, 1);
        chk("drop_nwr", nwr - w0, 0);
        chk("drop_ndone", ndone - n0, 0);
        send(8'hFF, 0);
        chk("after_drop_addr0", {wr_en, wr_addr}, {1'b1, 4'd0});
        send(8'h03, 1);
        idle(3);
        chk("after_drop_len", last_len, 10);

        // 20-beat packet: truncated
        n0 = ndone; w0 = nwr;
        for (int i = 0; i < 20; i++) send(8'hFF, i == 19);
        idle(3);
        chk("big_ndone", ndone - n0, 1);
        chk("big_len", last_len, 128);
        chk("big_trunc", last_trunc, 1);
        chk("big_nwr", nwr - w0, 16);
        chk("big_last_addr", last_addr, 15);

        // 16-beat packet: exactly fills memory
        w0 = nwr;
        for (int i = 0; i < 16; i++) send(8'hFF, i == 15);
        idle(3);
        chk("fill_len", last_len, 128);
        chk("fill_trunc", last_trunc, 0);
        chk("fill_nwr", nwr - w0, 16);

        // single-beat packet followed back-to-back by a 2-beat packet
        n0 = ndone;
        send(8'h01, 1);
        chk("single_wr", {wr_en, wr_addr}, {1'b1, 4'd0});
        send(8'hFF, 0);
        chk("single_done", done, 1);
        chk("single_len", byte_len, 1);
        chk("b2b_wr0", {wr_en, wr_addr}, {1'b1, 4'd0});
        send(8'hFF, 1);
        chk("b2b_wr1", {wr_en, wr_addr}, {1'b1, 4'd1});
        idle(3);
        chk("b2b_ndone", ndone - n0, 2);
        chk("b2b_len", last_len, 16);

        // TREADY stall mid-packet
        w0 = nwr;
        send(8'hFF, 0);
        TVALID = 1; TREADY = 0; TDATA = 64'hDEAD_BEEF_0BAD_F00D;
        idle(5);
        chk("stall_nwr", nwr - w0, 1);
        TVALID = 0;
        send(8'hFF, 0);
        chk("stall_resume", {wr_en, wr_addr}, {1'b1, 4'd1});
        send(8'hFF, 1);
        idle(3);
        chk("stall_len", last_len, 24);

        // 17 dropped packets saturate the counter
        mem_ready = 0;
        repeat (17) send(8'hFF, 1);
        mem_ready = 1;
        idle(1);
        chk("drop_sat", drop_cnt, 15);

        // reset mid-packet, with a beat on the reset edge
        send(8'hFF, 0);
        send(8'hFF, 0);
        rst = 1; TVALID = 1; TREADY = 1; TKEEP = 8'hFF;
        @(posedge clk); #1;
        rst = 0; TVALID = 0;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_len", byte_len, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        n0 = ndone;
        idle(4);
        chk("mid_rst_no_done", ndone - n0, 0);
        send(8'h0F, 1);
        chk("post_rst_wr0", {wr_en, wr_addr}, {1'b1, 4'd0});
        idle(3);
        chk("post_rst_len", last_len, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axistream_snooper_wide.md
AXISTREAM_SNOOPER_WIDE -- requirements
Module: axistream_snooper_wide

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning stream/memory word width in bits (multiple of 8, 32..512).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning packet-memory word address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning dropped-packet counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: ports clk and rst.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 TDATA  input  DATA_WIDTH  snooped stream data.
REQ-008 TKEEP  input  DATA_WIDTH/8  byte qualifiers, contiguous from bit 0.
REQ-009 TVALID  input  1  snooped valid.
REQ-010 TREADY  input  1  snooped ready (input; block never backpressures).
REQ-011 TLAST  input  1  end of packet.
REQ-012 mem_ready  input  1  packet memory free to accept a new packet.
REQ-013 wr_addr  output  ADDR_WIDTH  registered write word address.
REQ-014 wr_data  output  DATA_WIDTH  registered write data.
REQ-015 wr_en  output  1  registered write strobe.
REQ-016 done  output  1  one-cycle pulse, packet capture finished.
REQ-017 byte_len  output  32  captured byte count, valid while done=1.
REQ-018 trunc  output  1  packet exceeded memory, valid while done=1.
REQ-019 drop_cnt  output  CNT_WIDTH  packets ignored because mem_ready=0.

Function
REQ-020 Beat SHALL mean TVALID&TREADY in a cycle; non-beat cycles SHALL change no state except clearing the one-cycle done and wr_en pulses.
REQ-021 FSM states SHALL be IDLE, CAPTURE, FULL, SKIP.
REQ-022 IDLE, beat, mem_ready=1: write at address 0, byte count := popcount(TKEEP); TLAST -> schedule done, stay IDLE; else -> CAPTURE.
REQ-023 IDLE, beat, mem_ready=0: no write, drop_cnt increments saturating at 2^CNT_WIDTH-1; TLAST -> stay IDLE; else -> SKIP.
REQ-024 CAPTURE, beat: write at next address, count += popcount(TKEEP); mem_ready ignored; TLAST -> schedule done, go IDLE; else, if the address just written is 2^ADDR_WIDTH-1 -> FULL.
REQ-025 FULL, beat: no write, count unchanged, trunc flag set; TLAST -> schedule done, go IDLE.
REQ-026 SKIP, beat with TLAST -> IDLE; no writes, no done.
REQ-027 wr_en/wr_addr/wr_data SHALL assert exactly 1 cycle after the beat that caused them; wr_data = TDATA unmodified.
REQ-028 done SHALL pulse 1 cycle after the wr_en of the final written beat (2 cycles after the TLAST beat); byte_len and trunc SHALL be held with done and remain stable until the next done.
REQ-029 A new packet's first beat in the cycle directly after a TLAST beat SHALL be accepted normally (back-to-back, no dead cycle).
REQ-030 byte count SHALL be 32-bit; max is 2^ADDR_WIDTH*DATA_WIDTH/8; counting stops in FULL.
REQ-031 trunc SHALL be 0 for a packet that exactly fills memory with TLAST on the last address.

Reset
REQ-032 rst SHALL force state IDLE and wr_en, wr_addr, wr_data, done, byte_len, trunc, drop_cnt to 0 on the next edge, overriding any simultaneous beat.
REQ-033 After reset mid-packet, no done SHALL be issued for the aborted packet; the next beat SHALL be treated as a packet start.

Verification (DATA_WIDTH=64, ADDR_WIDTH=4, CNT_WIDTH=4)
REQ-034 3-beat packet, TKEEP FF,FF,0F, mem_ready=1 -> wr_en at addr 0,1,2 each 1 cycle after its beat; done 1 cycle after addr-2 write; byte_len=20, trunc=0.
REQ-035 2-beat packet with mem_ready=0 at first beat -> no wr_en, no done, drop_cnt 0->1; following packet captured from addr 0.
REQ-036 20-beat full-keep packet -> writes addr 0..15 only; done 2 cycles after TLAST beat; byte_len=128, trunc=1; 16-beat packet -> byte_len=128, trunc=0.
REQ-037 Single-beat packet TKEEP=01 -> wr_en addr 0, done next cycle, byte_len=1; immediately followed by second packet -> its first write at addr 0, no lost beat.
REQ-038 TVALID=1, TREADY=0 for 5 cycles mid-packet -> no writes, address resumes at next value; 17 dropped packets -> drop_cnt holds 15.
REQ-039 rst for 1 cycle after 2 captured beats -> all outputs 0 next cycle, no done; next beat written at addr 0.
